// File: rtl/nios2_oci_pkg.sv
// rtl/nios2_oci_pkg.sv - shared types and jdo field positions for the OCI memory arbiter
package nios2_oci_pkg;

  typedef enum logic [1:0] {IDLE, WR, RD, RDAT} oci_state_e;

  localparam int JDO_RD_BIT   = 35;
  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_WD_MSB   = 34;
  localparam int JDO_WD_LSB   = 3;
  localparam int OCI_DATA_W   = 32;

endpackage

// File: rtl/nios2_oci_rr_arb2.sv
// rtl/nios2_oci_rr_arb2.sv - two-way JTAG/CPU arbiter, round-robin under NIOS2_OCIMEM_RR_EN
module nios2_oci_rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic req_jtag,
  input  logic req_cpu,
  input  logic update,
  output logic gnt_jtag,
  output logic gnt_cpu
);

`ifdef NIOS2_OCIMEM_RR_EN
  // last_cpu=1 means the CPU held the most recent grant, so JTAG wins a tie
  logic last_cpu;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_cpu <= 1'b1;
    end else if (update) begin
      last_cpu <= gnt_cpu;
    end
  end

  assign gnt_jtag = req_jtag && (!req_cpu || last_cpu);
  assign gnt_cpu  = req_cpu && !gnt_jtag;
`else
  logic unused_arb;
  assign unused_arb = ^{clk, reset_n, update};

  assign gnt_jtag = req_jtag;
  assign gnt_cpu  = req_cpu && !req_jtag;
`endif

endmodule

// File: rtl/nios2_oci_mem_arbiter.sv
// rtl/nios2_oci_mem_arbiter.sv - OCI debug RAM sharing between JTAG and CPU; NIOS2_OCIMEM_RR_EN selects round-robin
module nios2_oci_mem_arbiter
  import nios2_oci_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = OCI_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  oci_state_e        state, state_d;
  logic              owner_jtag, owner_d;
  logic [ADDR_W-1:0] jaddr;
  logic              jrd_pend, jwr_pend;
  logic [DATA_W-1:0] jwdata;
  logic              gnt_jtag, gnt_cpu, arb_update;
  logic              jtag_busy, cpu_done;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  nios2_oci_rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_jtag (jrd_pend | jwr_pend),
    .req_cpu  (cpu_read | cpu_write),
    .update   (arb_update),
    .gnt_jtag (gnt_jtag),
    .gnt_cpu  (gnt_cpu)
  );

  // New JTAG commands are refused while one is queued or still touching the RAM
  assign jtag_busy = jrd_pend || jwr_pend || (owner_jtag && state != IDLE);

  always_comb begin
    state_d    = state;
    owner_d    = owner_jtag;
    arb_update = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_jtag) begin
          owner_d    = 1'b1;
          state_d    = jwr_pend ? WR : RD;
          arb_update = 1'b1;
        end else if (gnt_cpu) begin
          owner_d    = 1'b0;
          state_d    = cpu_read ? RD : WR;
          arb_update = 1'b1;
        end
      end
      WR:      state_d = IDLE;
      RD:      state_d = RDAT;
      RDAT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner_jtag    <= 1'b0;
      jaddr         <= '0;
      jrd_pend      <= 1'b0;
      jwr_pend      <= 1'b0;
      jwdata        <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      jtag_overrun  <= 1'b0;
    end else begin
      state      <= state_d;
      owner_jtag <= owner_d;
      if (arb_update && owner_d) begin
        jrd_pend <= 1'b0;
        jwr_pend <= 1'b0;
      end
      if (owner_jtag && (state == WR || state == RDAT)) begin
        jaddr         <= jaddr + ADDR_W'(1);
        monitor_ready <= 1'b1;
      end
      if (owner_jtag && state == RDAT) begin
        MonDReg <= ram_rdata;
      end
      if (take_action_ocimem_a) begin
        if (jtag_busy) begin
          jtag_overrun <= 1'b1;
        end else begin
          jaddr         <= jdo[JDO_ADDR_LSB +: ADDR_W];
          jrd_pend      <= jdo[JDO_RD_BIT];
          monitor_ready <= 1'b0;
        end
      end
      // Simultaneous a/b: a is taken, b is treated as an overrun
      if (take_action_ocimem_b) begin
        if (jtag_busy || take_action_ocimem_a) begin
          jtag_overrun <= 1'b1;
        end else begin
          jwr_pend      <= 1'b1;
          jwdata        <= jdo[JDO_WD_MSB:JDO_WD_LSB];
          monitor_ready <= 1'b0;
        end
      end
    end
  end

  // Outputs are gated by reset_n so an aborted write never reaches the RAM
  assign cpu_done        = reset_n && !owner_jtag && (state == WR || state == RDAT);
  assign cpu_waitrequest = !cpu_done;
  assign cpu_readdata    = (cpu_done && state == RDAT) ? ram_rdata : '0;
  assign ram_we          = reset_n && (state == WR);
  assign ram_addr        = owner_jtag ? jaddr : cpu_addr;
  assign ram_wdata       = owner_jtag ? jwdata : cpu_wdata;

endmodule

// File: tb/tb_nios2_oci_mem_arbiter.sv
// tb/tb_nios2_oci_mem_arbiter.sv - directed self-checking bench for nios2_oci_mem_arbiter
module tb_nios2_oci_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a, take_b;
  logic [7:0]  cpu_addr;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_wdata;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mon_dreg;
  logic        monitor_ready;
  logic        jtag_overrun;

  logic [31:0] mem [256];
  int          wr_count;
  logic [31:0] last_wr_data;
  int          checks;
  int          failures;
  int          saved_wr;

  nios2_oci_mem_arbiter dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .jdo                  (jdo),
    .take_action_ocimem_a (take_a),
    .take_action_ocimem_b (take_b),
    .cpu_addr             (cpu_addr),
    .cpu_read             (cpu_read),
    .cpu_write            (cpu_write),
    .cpu_wdata            (cpu_wdata),
    .cpu_waitrequest      (cpu_waitrequest),
    .cpu_readdata         (cpu_readdata),
    .ram_addr             (ram_addr),
    .ram_we               (ram_we),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (mon_dreg),
    .monitor_ready        (monitor_ready),
    .jtag_overrun         (jtag_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      wr_count      <= wr_count + 1;
      last_wr_data  <= ram_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] jdo_a(input logic rd, input logic [7:0] addr);
    logic [37:0] v;
    v        = '0;
    v[35]    = rd;
    v[24:17] = addr;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] v;
    v       = '0;
    v[34:3] = data;
    return v;
  endfunction

  task automatic pulse_a(input logic rd, input logic [7:0] addr);
    jdo    = jdo_a(rd, addr);
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [31:0] data);
    jdo    = jdo_b(data);
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; wr_count = 0; last_wr_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 32'h1234_5678;
    mem[8'h30] = 32'h3030_3030;
    mem[8'h05] = 32'hA5A5_0005;
    reset_n = 1'b0; jdo = '0; take_a = 1'b0; take_b = 1'b0;
    cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wdata = '0;
    tick(); tick();
    chk("rst_monitor_ready", monitor_ready, 1);
    chk("rst_mondreg", mon_dreg, 0);
    chk("rst_overrun", jtag_overrun, 0);
    chk("rst_waitrequest", cpu_waitrequest, 1);
    chk("rst_readdata", cpu_readdata, 0);
    chk("rst_ram_we", ram_we, 0);
    reset_n = 1'b1;
    tick();

    // JTAG write at 0x10
    pulse_a(1'b0, 8'h10);
    chk("wr_monitor_busy", monitor_ready, 0);
    pulse_b(32'hDEAD_BEEF);
    tick();
    chk("wr_we", ram_we, 1);
    chk("wr_addr", ram_addr, 8'h10);
    chk("wr_data", ram_wdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_monitor_ready", monitor_ready, 1);
    pulse_b(32'h1111_1111);
    tick();
    chk("wr_jaddr_inc", ram_addr, 8'h11);
    tick();

    // JTAG read from 0x20
    pulse_a(1'b1, 8'h20);
    tick();
    chk("rd_addr", ram_addr, 8'h20);
    tick(); tick();
    chk("rd_mondreg", mon_dreg, 32'h1234_5678);
    chk("rd_monitor_ready", monitor_ready, 1);
    pulse_b(32'h2222_2222);
    tick();
    chk("rd_jaddr_inc", ram_addr, 8'h21);
    tick();

    // Address wrap
    pulse_a(1'b0, 8'hFF);
    pulse_b(32'hCAFE_F00D);
    tick();
    chk("wrap_addr_ff", ram_addr, 8'hFF);
    tick();
    pulse_b(32'h0BAD_F00D);
    tick();
    chk("wrap_addr_00", ram_addr, 8'h00);
    tick();

    // Uncontended CPU write
    cpu_write = 1'b1; cpu_addr = 8'h07; cpu_wdata = 32'h0000_0077;
    tick();
    chk("cpu_wr_wait", cpu_waitrequest, 0);
    chk("cpu_wr_we", ram_we, 1);
    chk("cpu_wr_addr", ram_addr, 8'h07);
    chk("cpu_wr_data", ram_wdata, 32'h0000_0077);
    cpu_write = 1'b0;
    tick();

    // Tie with CPU last granted: JTAG first in both modes
    pulse_a(1'b1, 8'h30);
    cpu_read = 1'b1; cpu_addr = 8'h05;
    tick();
    chk("tie1_addr", ram_addr, 8'h30);
    chk("tie1_cpu_wait", cpu_waitrequest, 1);
    tick(); tick();
    chk("tie1_mondreg", mon_dreg, 32'h3030_3030);
    tick(); tick();
    chk("tie1_cpu_done", cpu_waitrequest, 0);
    chk("tie1_cpu_data", cpu_readdata, 32'hA5A5_0005);
    cpu_read = 1'b0;
    tick();

    // Tie with JTAG last granted
    pulse_b(32'h0000_0099);
    tick(); tick();
    pulse_a(1'b1, 8'h30);
    cpu_read = 1'b1; cpu_addr = 8'h05;
    tick();
`ifdef NIOS2_OCIMEM_RR_EN
    chk("tie2_addr", ram_addr, 8'h05);
`else
    chk("tie2_addr", ram_addr, 8'h30);
`endif
    for (int i = 0; i < 12 && cpu_waitrequest; i++) tick();
    chk("tie2_cpu_done", cpu_waitrequest, 0);
    chk("tie2_cpu_data", cpu_readdata, 32'hA5A5_0005);
    cpu_read = 1'b0;
    for (int i = 0; i < 12 && !monitor_ready; i++) tick();
    chk("tie2_monitor_ready", monitor_ready, 1);
    chk("tie2_mondreg", mon_dreg, 32'h3030_3030);
    tick();

    // Overrun: second write pulse one clock later is dropped
    pulse_b(32'h5555_5555);
    pulse_b(32'h6666_6666);
    chk("ovr_we", ram_we, 1);
    chk("ovr_data", ram_wdata, 32'h5555_5555);
    tick(); tick(); tick();
    chk("ovr_flag", jtag_overrun, 1);
    chk("ovr_last_write", last_wr_data, 32'h5555_5555);

    // Reset while in WR: write suppressed
    pulse_b(32'h7777_7777);
    tick();
    saved_wr = wr_count;
    reset_n = 1'b0;
    #1;
    chk("rst_wr_we_gated", ram_we, 0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("rst_wr_no_write", wr_count, saved_wr);
    chk("ovr_cleared", jtag_overrun, 0);
    chk("rst_wr_monitor", monitor_ready, 1);

    // Reset while in RD
    pulse_a(1'b1, 8'h20);
    tick();
    chk("rst_rd_addr", ram_addr, 8'h20);
    reset_n = 1'b0;
    tick();
    chk("rst_rd_wait", cpu_waitrequest, 1);
    chk("rst_rd_monitor", monitor_ready, 1);
    chk("rst_rd_mondreg", mon_dreg, 0);
    chk("rst_rd_we", ram_we, 0);
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("rst_rd_idle_monitor", monitor_ready, 1);
    chk("rst_rd_mondreg_kept", mon_dreg, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
